mul_fp_pipe: RTL and testbench
==============================

Name: mul_fp_pipe

Overview:
- Parametrised, fully pipelined IEEE-style floating-point multiplier. Generalises the fixed FP16 multiplier to any exponent/mantissa split, e.g. FP16 (5/10) or BF16 (8/7).
- Adds a valid/ready handshake with back-pressure, special-value handling (zero/inf/NaN), round-to-nearest-even and exception flags.
- Sits in the vector/systolic datapath wherever an FP product feeds an accumulator or writeback stage.

Parameters:
- EXP_W, 5, exponent field width (3..8).
- MAN_W, 10, stored mantissa width, excluding the hidden bit (2..10).
- BIAS, 2**(EXP_W-1)-1, exponent bias; derived, not overridden.
- Total word width W = 1+EXP_W+MAN_W.

Ports:
- clk  in  1  clock
- nRST  in  1  asynchronous active-low reset
- in_valid  in  1  operand pair valid
- in_ready  out  1  block can accept an operand pair this cycle
- a  in  W  operand A
- b  in  W  operand B
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- result  out  W  product
- flags  out  4  {invalid, overflow, underflow, inexact}, qualified by out_valid

Behaviour:
- One clock (clk); reset asynchronous, active-low (nRST).
- Reset: all stage valids, out_valid, result and flags go to 0 immediately, including mid-operation. In-flight data is discarded. in_ready reads 1 after reset.
- Pipeline stages:
  - S1: register a, b; classify each operand as zero/normal/inf/NaN.
  - S2: full (2*MAN_W+2)-bit significand product; signed exponent sum ea+eb-BIAS, EXP_W+2 bits wide.
  - S3: normalise, round, pack into the output register.
- Global stall: advance = out_ready | ~out_valid, and in_ready = advance.
  - A transfer occurs on a rising edge when in_valid & in_ready.
  - When advance=0, every stage holds, and result/flags stay stable while out_valid=1.
  - Bubbles are not squeezed; latency is fixed.
- Latency: a pair accepted at edge k drives out_valid=1 from edge k+3 when no stall occurs. Each cycle of advance=0 adds one cycle. Results leave in acceptance order, and throughput is 1 per cycle.
- Subnormal inputs (exp=0, mant!=0) are treated as signed zero (flush-to-zero). No flag is raised for them.
- Sign is always sa^sb, including for zero and inf results. The NaN sign is 0.
- Special cases, resolved in S1 and carried down the pipe:
  - Any NaN operand gives canonical qNaN {0, all-ones exponent, 1, zeros}. invalid=1 only if the NaN is signalling (mantissa MSB 0).
  - inf*0 gives canonical qNaN with invalid=1.
  - inf*finite-nonzero or inf*inf gives signed inf, no flags.
  - zero*finite gives signed zero, no flags.
- Normal path:
  - If the product MSB is set, the exponent increments by 1 and the product is taken one bit higher.
  - Round to nearest, ties to even, using guard, round and sticky (OR of all lower bits).
  - inexact=1 if any discarded bit is 1.
  - If rounding carries out of the significand, the exponent increments again and the mantissa becomes 0.
- Overflow: final exponent >= 2**EXP_W-1 gives signed inf with overflow=1 and inexact=1.
- Underflow: final biased exponent <= 0 gives signed zero (flush-to-zero) with underflow=1 and inexact=1.
- Flags are per-result and not sticky.

Test Plan:
- FP16, 0x3C00*0x3C00 -> result 0x3C00, flags 0000, out_valid exactly 3 cycles after acceptance; 0xC000*0x3C00 -> 0xC000.
- FP16, 0x3E00*0x3E00 (1.5*1.5) -> 0x4080; 0x3C01*0x3C01 -> 0x3C02 with inexact=1 (tie-free RNE). Also cover one exact tie that rounds to even.
- FP16, 0x7BFF*0x7BFF -> 0x7C00 with overflow and inexact set; 0x0400*0x0400 -> 0x0000 with underflow and inexact set; 0x8400*0x0400 -> 0x8000.
- FP16 specials:
  - 0x7C00*0x0000 -> 0x7E00 with invalid=1.
  - 0x7D00*0x3C00 (sNaN) -> 0x7E00 with invalid=1.
  - 0x7E00*0x3C00 -> 0x7E00 with invalid=0.
  - 0xFC00*0x4000 -> 0xFC00.
  - 0x0001*0x7BFF (subnormal) -> 0x0000.
- Back-pressure: stream 6 back-to-back pairs and hold out_ready=0 for 5 cycles once the first result appears -> in_ready=0 while stalled, result held stable, all 6 results delivered in order with none lost or duplicated. Assert nRST mid-stream -> outputs 0 at once and no stale result after release.
- BF16 build (EXP_W=8, MAN_W=7): 0x3F80*0x4000 -> 0x4000; 0x7F7F*0x4000 -> 0x7F80 with overflow set. Run a random regression against a reference model with RNE and flush-to-zero in both configurations.

Source files
------------

// File: rtl/mul_fp_pipe.sv
// Pipelined floating-point multiplier with a configurable exponent/mantissa split.
// Stages: operand capture, classify, significand product, normalise/round/pack.
module mul_fp_pipe #(
    parameter int unsigned EXP_W = 5,
    parameter int unsigned MAN_W = 10
) (
    input  logic                   clk,
    input  logic                   nRST,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [EXP_W+MAN_W:0]   a,
    input  logic [EXP_W+MAN_W:0]   b,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [EXP_W+MAN_W:0]   result,
    output logic [3:0]             flags
);

    localparam int unsigned W    = 1 + EXP_W + MAN_W;
    localparam int unsigned BIAS = 2**(EXP_W-1) - 1;
    localparam int unsigned PW   = 2*MAN_W + 2;
    localparam int unsigned XW   = EXP_W + 2;
    localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
    localparam logic signed [XW-1:0] EXP_MAX = XW'((2**EXP_W) - 1);

    logic advance;
    assign advance  = out_ready | ~out_valid;
    assign in_ready = advance;

    // Operand capture
    logic         v0_q;
    logic [W-1:0] a_q, b_q;

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            v0_q <= 1'b0;
            a_q  <= '0;
            b_q  <= '0;
        end else if (advance) begin
            v0_q <= in_valid;
            a_q  <= a;
            b_q  <= b;
        end
    end

    // Classification; subnormals fold into zero
    logic             sa, sb;
    logic [EXP_W-1:0] ea, eb;
    logic [MAN_W-1:0] ma, mb;
    logic             a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, a_snan, b_snan;
    logic             spec_d, inv_d;
    logic [W-1:0]     spec_res_d;

    assign {sa, ea, ma} = a_q;
    assign {sb, eb, mb} = b_q;
    assign a_zero = (ea == '0);
    assign b_zero = (eb == '0);
    assign a_inf  = (&ea) & (ma == '0);
    assign b_inf  = (&eb) & (mb == '0);
    assign a_nan  = (&ea) & (|ma);
    assign b_nan  = (&eb) & (|mb);
    assign a_snan = a_nan & ~ma[MAN_W-1];
    assign b_snan = b_nan & ~mb[MAN_W-1];

    always_comb begin
        spec_d     = 1'b1;
        inv_d      = 1'b0;
        spec_res_d = QNAN;
        if (a_nan | b_nan) begin
            inv_d = a_snan | b_snan;
        end else if ((a_inf & b_zero) | (b_inf & a_zero)) begin
            inv_d = 1'b1;
        end else if (a_inf | b_inf) begin
            spec_res_d = {sa ^ sb, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end else if (a_zero | b_zero) begin
            spec_res_d = {sa ^ sb, {(W-1){1'b0}}};
        end else begin
            spec_d = 1'b0;
        end
    end

    logic             v1_q, spec1_q, inv1_q, sign1_q;
    logic [W-1:0]     res1_q;
    logic [EXP_W-1:0] ea1_q, eb1_q;
    logic [MAN_W-1:0] ma1_q, mb1_q;

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            v1_q    <= 1'b0;
            spec1_q <= 1'b0;
            inv1_q  <= 1'b0;
            sign1_q <= 1'b0;
            res1_q  <= '0;
            ea1_q   <= '0;
            eb1_q   <= '0;
            ma1_q   <= '0;
            mb1_q   <= '0;
        end else if (advance) begin
            v1_q    <= v0_q;
            spec1_q <= spec_d;
            inv1_q  <= inv_d;
            sign1_q <= sa ^ sb;
            res1_q  <= spec_res_d;
            ea1_q   <= ea;
            eb1_q   <= eb;
            ma1_q   <= ma;
            mb1_q   <= mb;
        end
    end

    // Significand product and biased exponent sum
    logic                 v2_q, spec2_q, inv2_q, sign2_q;
    logic [W-1:0]         res2_q;
    logic [PW-1:0]        prod2_q;
    logic signed [XW-1:0] exp2_q;
    logic signed [XW-1:0] exp_sum;

    assign exp_sum = signed'({2'b00, ea1_q}) + signed'({2'b00, eb1_q}) - signed'(XW'(BIAS));

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            v2_q    <= 1'b0;
            spec2_q <= 1'b0;
            inv2_q  <= 1'b0;
            sign2_q <= 1'b0;
            res2_q  <= '0;
            prod2_q <= '0;
            exp2_q  <= '0;
        end else if (advance) begin
            v2_q    <= v1_q;
            spec2_q <= spec1_q;
            inv2_q  <= inv1_q;
            sign2_q <= sign1_q;
            res2_q  <= res1_q;
            prod2_q <= PW'({1'b1, ma1_q}) * PW'({1'b1, mb1_q});
            exp2_q  <= exp_sum;
        end
    end

    // Normalise so the hidden bit is dropped and the mantissa sits at the top of norm
    logic [PW-2:0]        norm;
    logic signed [XW-1:0] exp_n, exp_f;
    logic [MAN_W-1:0]     mant;
    logic [MAN_W:0]       mant_r;
    logic                 guard, rnd, sticky, rnd_up, inexact, ovf, udf;
    logic [W-1:0]         res_d;
    logic [3:0]           flags_d;

    always_comb begin
        norm    = prod2_q[PW-1] ? prod2_q[PW-2:0] : {prod2_q[PW-3:0], 1'b0};
        exp_n   = exp2_q + {{(XW-1){1'b0}}, prod2_q[PW-1]};
        mant    = norm[PW-2 -: MAN_W];
        guard   = norm[MAN_W];
        rnd     = norm[MAN_W-1];
        sticky  = |norm[MAN_W-2:0];
        inexact = guard | rnd | sticky;
        rnd_up  = guard & (rnd | sticky | mant[0]);
        mant_r  = {1'b0, mant} + {{MAN_W{1'b0}}, rnd_up};
        // Rounding carry leaves mant_r[MAN_W-1:0] all-zero, so only the exponent moves
        exp_f   = exp_n + {{(XW-1){1'b0}}, mant_r[MAN_W]};
        ovf     = (exp_f >= EXP_MAX);
        udf     = exp_f[XW-1] | (exp_f == '0);
        res_d   = {sign2_q, exp_f[EXP_W-1:0], mant_r[MAN_W-1:0]};
        flags_d = {3'b000, inexact};
        if (spec2_q) begin
            res_d   = res2_q;
            flags_d = {inv2_q, 3'b000};
        end else if (ovf) begin
            res_d   = {sign2_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            flags_d = 4'b0101;
        end else if (udf) begin
            res_d   = {sign2_q, {(W-1){1'b0}}};
            flags_d = 4'b0011;
        end
    end

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            out_valid <= 1'b0;
            result    <= '0;
            flags     <= '0;
        end else if (advance) begin
            out_valid <= v2_q;
            result    <= res_d;
            flags     <= flags_d;
        end
    end

endmodule

// File: tb/tb_mul_fp_pipe.sv
// Bench for mul_fp_pipe: FP16 and BF16 instances against an integer-arithmetic reference.
module tb_mul_fp_pipe;

    logic        clk = 1'b0;
    logic        nRST;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [15:0] a, b, result;
    logic [3:0]  flags;
    logic        bf_in_valid, bf_in_ready, bf_out_valid, bf_out_ready;
    logic [15:0] bf_a, bf_b, bf_result;
    logic [3:0]  bf_flags;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mul_fp_pipe u_fp16 (
        .clk(clk), .nRST(nRST), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
        .out_valid(out_valid), .out_ready(out_ready), .result(result), .flags(flags)
    );

    mul_fp_pipe #(.EXP_W(8), .MAN_W(7)) u_bf16 (
        .clk(clk), .nRST(nRST), .in_valid(bf_in_valid), .in_ready(bf_in_ready), .a(bf_a),
        .b(bf_b), .out_valid(bf_out_valid), .out_ready(bf_out_ready), .result(bf_result),
        .flags(bf_flags)
    );

    // Reference: decode to integers, multiply exactly, round by remainder comparison
    function automatic void ref_mul(input int ew, input int mw, input int x, input int y,
                                    output int r, output int f);
        int bias, emax, sx, sy, ex, ey, fx, fy, top, qnan, half_m, e, sh;
        longint p, q, rem, half;
        bit inexact;
        bias = (1 << (ew - 1)) - 1;
        emax = (1 << ew) - 1;
        sx = (x >> (ew + mw)) & 1;
        sy = (y >> (ew + mw)) & 1;
        ex = (x >> mw) & emax;
        ey = (y >> mw) & emax;
        fx = x & ((1 << mw) - 1);
        fy = y & ((1 << mw) - 1);
        top = (sx ^ sy) << (ew + mw);
        half_m = 1 << (mw - 1);
        qnan = (emax << mw) | half_m;
        f = 0;
        if ((ex == emax && fx != 0) || (ey == emax && fy != 0)) begin
            r = qnan;
            if ((ex == emax && fx != 0 && fx < half_m) || (ey == emax && fy != 0 && fy < half_m))
                f = 8;
        end else if ((ex == emax && ey == 0) || (ey == emax && ex == 0)) begin
            r = qnan;
            f = 8;
        end else if (ex == emax || ey == emax) begin
            r = top | (emax << mw);
        end else if (ex == 0 || ey == 0) begin
            r = top;
        end else begin
            p = longint'((1 << mw) + fx) * longint'((1 << mw) + fy);
            e = ex + ey - bias;
            sh = mw;
            if (p >= (longint'(1) << (2 * mw + 1))) begin
                e++;
                sh = mw + 1;
            end
            q = p >> sh;
            rem = p - (q << sh);
            half = longint'(1) << (sh - 1);
            inexact = (rem != 0);
            if (rem > half || (rem == half && q % 2 == 1)) q++;
            if (q == (longint'(1) << (mw + 1))) begin
                q = q >> 1;
                e++;
            end
            if (e >= emax) begin
                r = top | (emax << mw);
                f = 5;
            end else if (e <= 0) begin
                r = top;
                f = 3;
            end else begin
                r = top | (e << mw) | int'(q - (longint'(1) << mw));
                f = inexact ? 1 : 0;
            end
        end
    endfunction

    function automatic int rnd_op(input int ew, input int mw);
        int v, emax, bias;
        emax = (1 << ew) - 1;
        bias = (1 << (ew - 1)) - 1;
        v = int'($urandom) & ((1 << (1 + ew + mw)) - 1);
        if ($urandom_range(3, 0) != 0)
            v = (v & ~(emax << mw)) | ((bias - 3 + int'($urandom_range(6, 0))) << mw);
        return v;
    endfunction

    task automatic fp_op(input logic [15:0] x, input logic [15:0] y,
                         output logic [15:0] r, output logic [3:0] f, output int lat);
        @(negedge clk);
        in_valid = 1'b1; a = x; b = y; out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        r = result;
        f = flags;
    endtask

    task automatic bf_op(input logic [15:0] x, input logic [15:0] y,
                         output logic [15:0] r, output logic [3:0] f, output int lat);
        @(negedge clk);
        bf_in_valid = 1'b1; bf_a = x; bf_b = y; bf_out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bf_in_valid = 1'b0;
        lat = 0;
        while (!bf_out_valid && lat < 20) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        r = bf_result;
        f = bf_flags;
    endtask

    task automatic test_reset;
        #12;
        checks++;
        if (out_valid !== 1'b0 || result !== 16'h0 || flags !== 4'h0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_fp16: got v=%b r=%h f=%b rdy=%b want 0 0000 0000 1",
                     out_valid, result, flags, in_ready);
        end
        checks++;
        if (bf_out_valid !== 1'b0 || bf_result !== 16'h0 || bf_flags !== 4'h0) begin
            errors++;
            $display("FAIL reset_bf16: got v=%b r=%h f=%b want 0 0000 0000",
                     bf_out_valid, bf_result, bf_flags);
        end
        @(negedge clk);
        nRST = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_after_reset: got %b want 1", in_ready);
        end
    endtask

    task automatic test_basic;
        logic [15:0] r;
        logic [3:0]  f;
        int lat;
        fp_op(16'h3C00, 16'h3C00, r, f, lat);
        checks++;
        if (r !== 16'h3C00 || f !== 4'b0000) begin
            errors++;
            $display("FAIL one_times_one: got %h/%b want 3c00/0000", r, f);
        end
        checks++;
        if (lat !== 3) begin
            errors++;
            $display("FAIL latency: got %0d want 3", lat);
        end
        fp_op(16'hC000, 16'h3C00, r, f, lat);
        checks++;
        if (r !== 16'hC000 || f !== 4'b0000) begin
            errors++;
            $display("FAIL neg_two: got %h/%b want c000/0000", r, f);
        end
    endtask

    task automatic test_rounding;
        logic [15:0] va [4] = '{16'h3E00, 16'h3C01, 16'h3C01, 16'h3C03};
        logic [15:0] vb [4] = '{16'h3E00, 16'h3C01, 16'h3E00, 16'h3E00};
        logic [15:0] er [4] = '{16'h4080, 16'h3C02, 16'h3E02, 16'h3E04};
        logic [3:0]  ef [4] = '{4'b0000, 4'b0001, 4'b0001, 4'b0001};
        logic [15:0] r;
        logic [3:0]  f;
        int lat;
        for (int i = 0; i < 4; i++) begin
            fp_op(va[i], vb[i], r, f, lat);
            checks++;
            if (r !== er[i] || f !== ef[i]) begin
                errors++;
                $display("FAIL rounding_%0d: %h*%h got %h/%b want %h/%b",
                         i, va[i], vb[i], r, f, er[i], ef[i]);
            end
        end
    endtask

    task automatic test_range;
        logic [15:0] va [3] = '{16'h7BFF, 16'h0400, 16'h8400};
        logic [15:0] vb [3] = '{16'h7BFF, 16'h0400, 16'h0400};
        logic [15:0] er [3] = '{16'h7C00, 16'h0000, 16'h8000};
        logic [3:0]  ef [3] = '{4'b0101, 4'b0011, 4'b0011};
        logic [15:0] r;
        logic [3:0]  f;
        int lat;
        for (int i = 0; i < 3; i++) begin
            fp_op(va[i], vb[i], r, f, lat);
            checks++;
            if (r !== er[i] || f !== ef[i]) begin
                errors++;
                $display("FAIL range_%0d: %h*%h got %h/%b want %h/%b",
                         i, va[i], vb[i], r, f, er[i], ef[i]);
            end
        end
    endtask

    task automatic test_specials;
        logic [15:0] va [6] = '{16'h7C00, 16'h7D00, 16'h7E00, 16'hFC00, 16'h0001, 16'hC000};
        logic [15:0] vb [6] = '{16'h0000, 16'h3C00, 16'h3C00, 16'h4000, 16'h7BFF, 16'h0000};
        logic [15:0] er [6] = '{16'h7E00, 16'h7E00, 16'h7E00, 16'hFC00, 16'h0000, 16'h8000};
        logic [3:0]  ef [6] = '{4'b1000, 4'b1000, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
        logic [15:0] r;
        logic [3:0]  f;
        int lat;
        for (int i = 0; i < 6; i++) begin
            fp_op(va[i], vb[i], r, f, lat);
            checks++;
            if (r !== er[i] || f !== ef[i]) begin
                errors++;
                $display("FAIL special_%0d: %h*%h got %h/%b want %h/%b",
                         i, va[i], vb[i], r, f, er[i], ef[i]);
            end
        end
    endtask

    task automatic test_back_to_back;
        logic [15:0] va [6] = '{16'h3C00, 16'h3E00, 16'h3C01, 16'hC000, 16'h4400, 16'h5000};
        logic [15:0] vb [6] = '{16'h4000, 16'h3E00, 16'h3C01, 16'h3C00, 16'h3555, 16'h2C00};
        int er [6];
        int ef [6];
        int sent = 0, got = 0, stall = 0, extra = 0;
        bit started = 0;
        logic [15:0] held = '0;
        for (int i = 0; i < 6; i++) ref_mul(5, 10, int'(va[i]), int'(vb[i]), er[i], ef[i]);
        for (int cyc = 0; cyc < 60 && got < 6; cyc++) begin
            @(negedge clk);
            if (out_valid && !started) begin
                started = 1;
                stall = 5;
                held = result;
            end
            out_ready = (stall == 0);
            in_valid = (sent < 6);
            a = va[sent % 6];
            b = vb[sent % 6];
            #1;
            if (stall > 0) begin
                checks++;
                if (in_ready !== 1'b0 || result !== held || out_valid !== 1'b1) begin
                    errors++;
                    $display("FAIL stall_hold: got rdy=%b v=%b r=%h want rdy=0 v=1 r=%h",
                             in_ready, out_valid, result, held);
                end
                stall--;
            end
            if (in_valid && in_ready) sent++;
            if (out_valid && out_ready) begin
                checks++;
                if (result !== 16'(er[got]) || flags !== 4'(ef[got])) begin
                    errors++;
                    $display("FAIL b2b_%0d: got %h/%b want %h/%b",
                             got, result, flags, 16'(er[got]), 4'(ef[got]));
                end
                got++;
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int cyc = 0; cyc < 6; cyc++) begin
            @(negedge clk);
            if (out_valid) extra++;
        end
        checks++;
        if (got !== 6 || sent !== 6 || extra !== 0) begin
            errors++;
            $display("FAIL b2b_count: got sent=%0d recv=%0d extra=%0d want 6 6 0",
                     sent, got, extra);
        end
    endtask

    task automatic test_reset_mid_stream;
        bit had_valid = 0;
        int extra = 0;
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            a = 16'h3C00 + 16'(i);
            b = 16'h4000;
            if (out_valid) had_valid = 1;
        end
        #2;
        nRST = 1'b0;
        in_valid = 1'b0;
        #1;
        checks++;
        if (had_valid !== 1'b1 || out_valid !== 1'b0 || result !== 16'h0 || flags !== 4'h0) begin
            errors++;
            $display("FAIL reset_async: got seen=%b v=%b r=%h f=%b want 1 0 0000 0000",
                     had_valid, out_valid, result, flags);
        end
        @(negedge clk);
        @(negedge clk);
        nRST = 1'b1;
        for (int cyc = 0; cyc < 8; cyc++) begin
            @(negedge clk);
            if (out_valid) extra++;
        end
        checks++;
        if (extra !== 0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_stale: got extra=%0d rdy=%b want 0 1", extra, in_ready);
        end
    endtask

    task automatic test_bf16;
        logic [15:0] r;
        logic [3:0]  f;
        int lat;
        bf_op(16'h3F80, 16'h4000, r, f, lat);
        checks++;
        if (r !== 16'h4000 || f !== 4'b0000 || lat !== 3) begin
            errors++;
            $display("FAIL bf16_one_two: got %h/%b lat=%0d want 4000/0000 lat=3", r, f, lat);
        end
        bf_op(16'h7F7F, 16'h4000, r, f, lat);
        checks++;
        if (r !== 16'h7F80 || f !== 4'b0101) begin
            errors++;
            $display("FAIL bf16_overflow: got %h/%b want 7f80/0101", r, f);
        end
    endtask

    task automatic test_random;
        int qr[$], qf[$], br[$], bq[$];
        int r, f, er, ef;
        for (int cyc = 0; cyc < 420; cyc++) begin
            @(negedge clk);
            in_valid     = (cyc < 400) && ($urandom_range(1, 0) == 1);
            a            = 16'(rnd_op(5, 10));
            b            = 16'(rnd_op(5, 10));
            out_ready    = (cyc >= 400) || ($urandom_range(3, 0) != 0);
            bf_in_valid  = (cyc < 400) && ($urandom_range(1, 0) == 1);
            bf_a         = 16'(rnd_op(8, 7));
            bf_b         = 16'(rnd_op(8, 7));
            bf_out_ready = (cyc >= 400) || ($urandom_range(3, 0) != 0);
            #1;
            if (in_valid && in_ready) begin
                ref_mul(5, 10, int'(a), int'(b), r, f);
                qr.push_back(r);
                qf.push_back(f);
            end
            if (bf_in_valid && bf_in_ready) begin
                ref_mul(8, 7, int'(bf_a), int'(bf_b), r, f);
                br.push_back(r);
                bq.push_back(f);
            end
            if (out_valid && out_ready) begin
                er = (qr.size() > 0) ? qr.pop_front() : -1;
                ef = (qf.size() > 0) ? qf.pop_front() : -1;
                checks++;
                if (er < 0 || result !== 16'(er) || flags !== 4'(ef)) begin
                    errors++;
                    $display("FAIL rand_fp16: got %h/%b want %h/%b (queued=%0d)",
                             result, flags, 16'(er), 4'(ef), er >= 0);
                end
            end
            if (bf_out_valid && bf_out_ready) begin
                er = (br.size() > 0) ? br.pop_front() : -1;
                ef = (bq.size() > 0) ? bq.pop_front() : -1;
                checks++;
                if (er < 0 || bf_result !== 16'(er) || bf_flags !== 4'(ef)) begin
                    errors++;
                    $display("FAIL rand_bf16: got %h/%b want %h/%b (queued=%0d)",
                             bf_result, bf_flags, 16'(er), 4'(ef), er >= 0);
                end
            end
        end
        checks++;
        if (qr.size() != 0 || br.size() != 0) begin
            errors++;
            $display("FAIL rand_drain: got pending fp16=%0d bf16=%0d want 0 0",
                     qr.size(), br.size());
        end
    endtask

    initial begin
        nRST = 1'b0;
        in_valid = 1'b0; a = '0; b = '0; out_ready = 1'b1;
        bf_in_valid = 1'b0; bf_a = '0; bf_b = '0; bf_out_ready = 1'b1;
        test_reset();
        test_basic();
        test_rounding();
        test_range();
        test_specials();
        test_back_to_back();
        test_reset_mid_stream();
        test_bf16();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
